// File: rtl/formula_2_result_buffer.sv
// formula_2_result_buffer: show-ahead result FIFO with issue-credit tracking for the formula_2 pipe.
// Captures every res_vld/res beat and replays it on a valid/ready port; issue_ok throttles the
// upstream issuer so results already in flight always have a slot.
// Optional feature macro: FORMULA_2_RESULT_BUFFER_STATS_EN adds res_cnt and max_fill outputs.
module formula_2_result_buffer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_vld,
  input  logic             res_vld,
  input  logic [WIDTH-1:0] res,
  output logic             issue_ok,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_rdy,
  output logic [CNT_W-1:0] fill,
  output logic             overflow,
  output logic             issue_err
`ifdef FORMULA_2_RESULT_BUFFER_STATS_EN
  ,
  output logic [31:0]      res_cnt,
  output logic [CNT_W-1:0] max_fill
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] credits_used;
  logic [CNT_W-1:0] fill_nxt;
  logic [CNT_W-1:0] credits_nxt;
  logic             full;
  logic             pop;
  logic             push_ok;

  // Status and handshake derived only from registered state (no path from out_rdy to issue_ok).
  assign out_vld  = (fill != '0);
  assign out_data = mem[rd_ptr];
  assign issue_ok = (credits_used < CNT_W'(DEPTH));
  assign full     = (fill == CNT_W'(DEPTH));
  assign pop      = out_vld & out_rdy;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign push_ok  = res_vld & (~full | pop);

  // Next occupancy: push and pop together leave fill unchanged.
  always_comb begin
    fill_nxt = fill;
    if (push_ok && !pop) begin
      fill_nxt = fill + CNT_W'(1);
    end else if (pop && !push_ok) begin
      fill_nxt = fill - CNT_W'(1);
    end
  end

  // Next credit count: saturates at DEPTH on an illegal issue, never drops below zero.
  always_comb begin
    credits_nxt = credits_used;
    if (issue_vld && !pop && issue_ok) begin
      credits_nxt = credits_used + CNT_W'(1);
    end else if (pop && !issue_vld && (credits_used != '0)) begin
      credits_nxt = credits_used - CNT_W'(1);
    end
  end

  // Storage write; the array itself carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= res;
    end
  end

  // Pointers, counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      fill         <= '0;
      credits_used <= '0;
      overflow     <= 1'b0;
      issue_err    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fill         <= fill_nxt;
      credits_used <= credits_nxt;
      if (res_vld && !push_ok) begin
        overflow <= 1'b1;
      end
      if (issue_vld && !issue_ok) begin
        issue_err <= 1'b1;
      end
    end
  end

`ifdef FORMULA_2_RESULT_BUFFER_STATS_EN
  // Pop counter (wraps modulo 2^32) and occupancy high-water mark.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_cnt  <= '0;
      max_fill <= '0;
    end else begin
      if (pop) begin
        res_cnt <= res_cnt + 32'(1);
      end
      if (fill_nxt > max_fill) begin
        max_fill <= fill_nxt;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // Stored results can never exceed the credits that admitted them.
  always @(posedge clk) begin
    if (!rst) begin
      assert (fill <= credits_used);
    end
  end
`endif

endmodule
